// File: rtl/uart_psram_host.sv
// rtl/uart_psram_host.sv - PSRAM-over-UART command initiator: 8N1 frame TX, 2-byte read response RX
module uart_psram_host #(
    parameter int          DELAY_FRAMES = 234,
    parameter int          RESP_TIMEOUT = 270000,
    parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        busy,
    output logic        wr_done,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout
);
    localparam int BIT_W = $clog2(DELAY_FRAMES + 1);
    localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DELAY_FRAMES - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(DELAY_FRAMES / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_TX_START, S_TX_DATA, S_TX_STOP, S_WAIT_RSP} state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    state_t           state;
    rx_state_t        rx_state;
    logic             is_write;
    logic [23:0]      addr;
    logic [15:0]      wdata;
    logic [2:0]       byte_idx;
    logic [2:0]       bit_idx;
    logic [BIT_W-1:0] bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       tx_shift;
    logic [7:0]       cur_byte;
    logic [2:0]       last_idx;
    logic [7:0]       rsp_lo;
    logic             got_first;
    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       rx_bit;
    logic [BIT_W-1:0] rx_cnt;
    logic [7:0]       rx_shift;
    logic             rx_valid;

    assign busy     = !cmd_ready;
    assign last_idx = is_write ? 3'd6 : 3'd4;

    always_comb begin
        cur_byte = PAD_BYTE;
        case (byte_idx)
            3'd0:    cur_byte = is_write ? 8'h57 : 8'h52;
            3'd1:    cur_byte = addr[7:0];
            3'd2:    cur_byte = addr[15:8];
            3'd3:    cur_byte = addr[23:16];
            3'd4:    cur_byte = is_write ? wdata[7:0] : PAD_BYTE;
            3'd5:    cur_byte = wdata[15:8];
            default: cur_byte = PAD_BYTE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            uart_tx     <= 1'b1;
            cmd_ready   <= 1'b1;
            wr_done     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_data    <= 16'h0000;
            is_write    <= 1'b0;
            addr        <= 24'h0;
            wdata       <= 16'h0;
            byte_idx    <= 3'd0;
            bit_idx     <= 3'd0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            tx_shift    <= 8'h00;
            rsp_lo      <= 8'h00;
            got_first   <= 1'b0;
        end else begin
            wr_done     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        is_write  <= cmd_write;
                        addr      <= cmd_addr;
                        wdata     <= cmd_wdata;
                        byte_idx  <= 3'd0;
                        bit_cnt   <= '0;
                        uart_tx   <= 1'b0;
                        cmd_ready <= 1'b0;
                        state     <= S_TX_START;
                    end
                end
                S_TX_START: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        bit_idx  <= 3'd0;
                        tx_shift <= cur_byte;
                        uart_tx  <= cur_byte[0];
                        state    <= S_TX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_TX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= S_TX_STOP;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            uart_tx  <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_TX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (byte_idx != last_idx) begin
                            byte_idx <= byte_idx + 1'b1;
                            uart_tx  <= 1'b0;
                            state    <= S_TX_START;
                        end else if (is_write) begin
                            wr_done   <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            tmo_cnt   <= '0;
                            got_first <= 1'b0;
                            state     <= S_WAIT_RSP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_WAIT_RSP: begin
                    // A received byte wins over a timeout landing on the same cycle
                    if (rx_valid && !got_first) begin
                        rsp_lo    <= rx_shift;
                        got_first <= 1'b1;
                        tmo_cnt   <= '0;
                    end else if (rx_valid) begin
                        rsp_data  <= {rx_shift, rsp_lo};
                        rsp_valid <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_timeout <= 1'b1;
                        cmd_ready   <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_state <= R_IDLE;
            rx_bit   <= 3'd0;
            rx_cnt   <= '0;
            rx_shift <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_s     <= rx_meta;
            rx_valid <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_s) rx_state <= R_START;
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= R_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_valid <= rx_s;
                        rx_state <= R_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_psram_host.sv
// tb/tb_uart_psram_host.sv - randomized bench for uart_psram_host against a frame/timing reference model
module tb_uart_psram_host;
    localparam int D    = 8;
    localparam int T    = 400;
    localparam int MAXC = 2000;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [23:0] cmd_addr = 24'h0;
    logic [15:0] cmd_wdata = 16'h0;
    logic        uart_rx = 1'b1;
    logic        cmd_ready;
    logic        uart_tx;
    logic        busy;
    logic        wr_done;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;

    uart_psram_host #(.DELAY_FRAMES(D), .RESP_TIMEOUT(T), .PAD_BYTE(8'h00)) dut (
        .sys_clk(sys_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .busy(busy), .wr_done(wr_done),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_pass = 0;
    bit          rx_wave[$];
    logic [7:0]  exp_frame[$];
    logic        tx_cap [MAXC];
    logic [15:0] last_rsp = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic rx_idle(input int n);
        repeat (n) rx_wave.push_back(1'b1);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) repeat (D) rx_wave.push_back(f[i]);
    endtask

    task automatic model_frame(input logic wr, input logic [23:0] a, input logic [15:0] d);
        exp_frame.delete();
        exp_frame.push_back(wr ? 8'h57 : 8'h52);
        exp_frame.push_back(a[7:0]);
        exp_frame.push_back(a[15:8]);
        exp_frame.push_back(a[23:16]);
        if (wr) begin
            exp_frame.push_back(d[7:0]);
            exp_frame.push_back(d[15:8]);
        end
        exp_frame.push_back(8'h00);
    endtask

    // Full two-byte response after the TX frame; returns the legal rsp_valid window
    task automatic build_rsp(input logic [7:0] b0, input logic [7:0] b1, input int g, input int g2,
                             output int lo, output int hi);
        int st;
        rx_wave.delete();
        rx_idle(50 * D + g);
        rx_byte(b0, 1'b1);
        rx_idle(g2);
        st = rx_wave.size();
        rx_byte(b1, 1'b1);
        lo = st + 9 * D + D / 2;
        hi = st + 10 * D + 4;
    endtask

    // kind: 0 write done, 1 read data, 2 read timeout, 3 reset abort at rst_at
    task automatic run_cmd(input logic wr, input logic [23:0] a, input logic [15:0] d, input int kind,
                           input int win_lo, input int win_hi, input logic [15:0] exp_data,
                           input int rst_at, input string tag);
        int done_c, cap_n, n_wr, n_rv, n_to, nbytes, bad_idle, idx;
        logic [15:0] got_data;
        logic [9:0]  got_f;
        done_c = -1; n_wr = 0; n_rv = 0; n_to = 0; bad_idle = 0; got_data = 16'h0;
        model_frame(wr, a, d);
        check_eq({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        for (int c = 0; c < MAXC; c++) begin
            tx_cap[c] = uart_tx;
            if (wr_done) n_wr++;
            if (rsp_timeout) n_to++;
            if (rsp_valid) begin
                n_rv++;
                got_data = rsp_data;
            end
            if ((kind == 0 && wr_done) || (kind == 1 && rsp_valid) || (kind == 2 && rsp_timeout)) begin
                done_c = c;
                if (kind == 0) check_eq({tag, "_ready_at_done"}, 32'(cmd_ready), 32'd1);
                break;
            end
            if (c == rst_at) begin
                check_eq({tag, "_tx_low_pre_rst"}, 32'(uart_tx), 32'd0);
                rst = 1'b1;
                #1;
                check_eq({tag, "_tx_high_in_rst"}, 32'(uart_tx), 32'd1);
                check_eq({tag, "_ready_in_rst"}, 32'(cmd_ready), 32'd1);
                @(negedge sys_clk);
                rst = 1'b0;
                for (int k = 0; k < 20 * D; k++) begin
                    @(negedge sys_clk);
                    if (wr_done) n_wr++;
                    if (rsp_valid) n_rv++;
                    if (rsp_timeout) n_to++;
                    if (!uart_tx) bad_idle++;
                end
                done_c = c;
                break;
            end
            uart_rx = (c < rx_wave.size()) ? rx_wave[c] : 1'b1;
            if (c >= 3 && c < 12) begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom);
                cmd_addr  = 24'($urandom);
                cmd_wdata = 16'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge sys_clk);
        end
        cmd_valid = 1'b0;
        uart_rx = 1'b1;
        cap_n = (done_c < 0) ? MAXC : done_c;

        if (kind == 3) begin
            check_eq({tag, "_tx_idle_after_rst"}, 32'(bad_idle), 32'd0);
        end else if (win_lo == win_hi) begin
            check_eq({tag, "_done_cycle"}, 32'(done_c), 32'(win_lo));
        end else begin
            if (!(done_c >= win_lo && done_c <= win_hi))
                $display("  %s: event at cycle %0d, window %0d..%0d", tag, done_c, win_lo, win_hi);
            check_eq({tag, "_done_in_window"}, 32'(done_c >= win_lo && done_c <= win_hi), 32'd1);
        end
        check_eq({tag, "_n_wr_done"}, 32'(n_wr), 32'(kind == 0));
        check_eq({tag, "_n_rsp_valid"}, 32'(n_rv), 32'(kind == 1));
        check_eq({tag, "_n_timeout"}, 32'(n_to), 32'(kind == 2));

        nbytes = (kind == 3) ? 3 : exp_frame.size();
        for (int b = 0; b < nbytes; b++) begin
            for (int k = 0; k < 10; k++) begin
                idx = (b * 10 + k) * D + D / 2;
                got_f[k] = (idx < cap_n) ? tx_cap[idx] : 1'bx;
            end
            check_eq($sformatf("%s_tx_byte%0d", tag, b), 32'(got_f), 32'({1'b1, exp_frame[b], 1'b0}));
        end
        if (kind == 1 || kind == 2) begin
            bad_idle = 0;
            for (int c = exp_frame.size() * 10 * D; c < cap_n; c++) if (tx_cap[c] !== 1'b1) bad_idle++;
            check_eq({tag, "_tx_idle_wait"}, 32'(bad_idle), 32'd0);
        end
        if (kind == 1) begin
            check_eq({tag, "_rsp_data"}, 32'(got_data), 32'(exp_data));
            last_rsp = exp_data;
        end
        if (kind == 2) check_eq({tag, "_rsp_data_held"}, 32'(rsp_data), 32'(last_rsp));
        rx_wave.delete();
    endtask

    task automatic drive_idle(input string tag);
        int n_p;
        n_p = 0;
        cmd_valid = 1'b0;
        for (int c = 0; c < rx_wave.size(); c++) begin
            uart_rx = rx_wave[c];
            @(negedge sys_clk);
            if (rsp_valid || wr_done || rsp_timeout) n_p++;
        end
        uart_rx = 1'b1;
        check_eq({tag, "_no_pulse_idle"}, 32'(n_p), 32'd0);
        rx_wave.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi, st;
        logic [7:0]  b0, b1;
        logic [23:0] ra;
        logic [15:0] rd;

        repeat (2) @(negedge sys_clk);
        check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wr_done", 32'(wr_done), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        @(negedge sys_clk);

        run_cmd(1'b1, 24'h123456, 16'hBEEF, 0, 70 * D, 70 * D, 16'h0, -1, "wr_beef");

        build_rsp(8'h34, 8'h12, 3, 5, lo, hi);
        run_cmd(1'b0, 24'h0000AB, 16'h0, 1, lo, hi, 16'h1234, -1, "rd_ab");

        run_cmd(1'b0, 24'h00C0DE, 16'h0, 2, 50 * D + T, 50 * D + T, 16'h0, -1, "rd_tmo");

        rx_wave.delete();
        rx_idle(50 * D + 5);
        rx_wave.push_back(1'b0);
        rx_wave.push_back(1'b0);
        rx_idle(3 * D);
        rx_byte(8'hA5, 1'b0);
        rx_idle(2 * D);
        rx_byte(8'h01, 1'b1);
        rx_idle(7);
        st = rx_wave.size();
        rx_byte(8'h02, 1'b1);
        run_cmd(1'b0, 24'h3F00AA, 16'h0, 1, st + 9 * D + D / 2, st + 10 * D + 4, 16'h0201, -1, "rd_glitch");

        run_cmd(1'b1, 24'($urandom), 16'($urandom), 3, 0, 0, 16'h0, 30 * D + 2, "wr_rst");
        b0 = 8'($urandom); b1 = 8'($urandom);
        build_rsp(b0, b1, 10, 0, lo, hi);
        run_cmd(1'b0, 24'($urandom), 16'h0, 1, lo, hi, {b1, b0}, -1, "rd_after_rst");

        rx_wave.delete();
        rx_idle(5);
        rx_byte(8'($urandom), 1'b1);
        rx_idle(3);
        rx_byte(8'($urandom), 1'b1);
        rx_idle(2 * D);
        drive_idle("stray");
        b0 = 8'($urandom); b1 = 8'($urandom);
        build_rsp(b0, b1, 0, 12, lo, hi);
        run_cmd(1'b0, 24'($urandom), 16'h0, 1, lo, hi, {b1, b0}, -1, "rd_stray");

        rx_wave.delete();
        rx_idle(50 * D + 20);
        st = rx_wave.size();
        rx_byte(8'h77, 1'b1);
        run_cmd(1'b0, 24'($urandom), 16'h0, 2, st + 9 * D + D / 2 + T, st + 10 * D + T + 4, 16'h0, -1,
                "rd_partial");

        for (int i = 0; i < 8; i++) begin
            ra = 24'($urandom);
            rd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                run_cmd(1'b1, ra, rd, 0, 70 * D, 70 * D, 16'h0, -1, $sformatf("rnd_wr%0d", i));
            end else begin
                b0 = 8'($urandom); b1 = 8'($urandom);
                build_rsp(b0, b1, $urandom_range(0, 20), $urandom_range(0, 30), lo, hi);
                run_cmd(1'b0, ra, 16'h0, 1, lo, hi, {b1, b0}, -1, $sformatf("rnd_rd%0d", i));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
